reg_axi_bridge: RTL and testbench

Parametrised AXI4-Lite slave to register-bus bridge, the next generation of our single-access AXI-Lite register translator. It accepts AW, W and AR independently and serialises them onto one request/acknowledge register port with wait-state support. It arbitrates fairly between pending reads and writes, decodes a configurable address window (DECERR outside it), and converts register-side errors and timeouts into SLVERR. It sits between the AXI-Lite interconnect and each block's register file.

---
 rtl/reg_axi_bridge_if.sv | 31 +++
 rtl/reg_axi_bridge.sv | 142 ++++++++++++++
 tb/tb_reg_axi_bridge.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_axi_bridge_if.sv
// reg_axi_bridge_if: AXI4-Lite channel bundle between the interconnect and the register bridge
interface reg_axi_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/reg_axi_bridge.sv
// reg_axi_bridge: AXI4-Lite slave serialised onto a req/ack register port with window decode and timeout
module reg_axi_bridge #(
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_BASE      = '0,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_SPAN      = 'h1000,
  parameter int                        TIMEOUT_CYCLES = 255
) (
  input  logic                        s_axi_aclk,
  input  logic                        s_axi_areset,
  reg_axi_bridge_if.slave             s_axi,
  output logic                        reg_wr_req,
  output logic                        reg_rd_req,
  output logic [AXI_ADDR_WIDTH-1:0]   reg_addr,
  output logic [AXI_DATA_WIDTH-1:0]   reg_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] reg_wstrb,
  input  logic                        reg_ack,
  input  logic                        reg_err,
  input  logic [AXI_DATA_WIDTH-1:0]   reg_rdata
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TO_EN = TIMEOUT_CYCLES > 0;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;

  state_t                        state, state_nx;
  logic                          aw_held, w_held, ar_held;
  logic [AXI_ADDR_WIDTH-1:0]     awaddr_q, araddr_q;
  logic [AXI_DATA_WIDTH-1:0]     wdata_q;
  logic [AXI_DATA_WIDTH/8-1:0]   wstrb_q;
  logic                          last_wr;
  logic [CW-1:0]                 cnt;
  logic [1:0]                    resp;
  logic [AXI_DATA_WIDTH-1:0]     rdata_q;
  logic                          aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic                          pick_wr, pick_rd, grant, grant_dec, timeout;
  logic [AXI_ADDR_WIDTH-1:0]     grant_off;

  assign s_axi.awready = !aw_held && !s_axi_areset;
  assign s_axi.wready  = !w_held && !s_axi_areset;
  assign s_axi.arready = !ar_held && !s_axi_areset;
  assign s_axi.bvalid  = state == WR_RESP;
  assign s_axi.rvalid  = state == RD_RESP;
  assign s_axi.bresp   = resp;
  assign s_axi.rresp   = resp;
  assign s_axi.rdata   = rdata_q;
  assign reg_wr_req    = state == WR_REQ;
  assign reg_rd_req    = state == RD_REQ;

  assign aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_hs  = s_axi.wvalid && s_axi.wready;
  assign ar_hs = s_axi.arvalid && s_axi.arready;
  assign b_hs  = s_axi.bvalid && s_axi.bready;
  assign r_hs  = s_axi.rvalid && s_axi.rready;

  // Fair pick: on a tie take the opposite of the last granted type
  assign pick_wr   = state == IDLE && aw_held && w_held && (!ar_held || !last_wr);
  assign pick_rd   = state == IDLE && ar_held && !pick_wr;
  assign grant     = pick_wr || pick_rd;
  assign grant_off = (pick_wr ? awaddr_q : araddr_q) - ADDR_BASE;
  assign grant_dec = grant_off >= ADDR_SPAN;
  assign timeout   = TO_EN && cnt == CNT_LAST;

  // Channel holding flags: set on handshake, released by the matching response handshake
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      ar_held <= 1'b0;
    end else begin
      aw_held <= aw_hs ? 1'b1 : b_hs ? 1'b0 : aw_held;
      w_held  <= w_hs ? 1'b1 : b_hs ? 1'b0 : w_held;
      ar_held <= ar_hs ? 1'b1 : r_hs ? 1'b0 : ar_held;
    end
  end

  // Captured address/data of the held transactions
  always_ff @(posedge s_axi_aclk) begin
    if (aw_hs) awaddr_q <= s_axi.awaddr;
    if (ar_hs) araddr_q <= s_axi.araddr;
    if (w_hs) begin
      wdata_q <= s_axi.wdata;
      wstrb_q <= s_axi.wstrb;
    end
  end

  // State register
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) state <= IDLE;
    else state <= state_nx;
  end

  // Next-state: decode errors skip the register request; ack takes priority over timeout
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = pick_wr ? (grant_dec ? WR_RESP : WR_REQ) :
                          pick_rd ? (grant_dec ? RD_RESP : RD_REQ) : IDLE;
      WR_REQ:  state_nx = (reg_ack || timeout) ? WR_RESP : WR_REQ;
      RD_REQ:  state_nx = (reg_ack || timeout) ? RD_RESP : RD_REQ;
      WR_RESP: state_nx = s_axi.bready ? IDLE : WR_RESP;
      RD_RESP: state_nx = s_axi.rready ? IDLE : RD_RESP;
      default: state_nx = IDLE;
    endcase
  end

  // Grant loads the register port; REQ cycles resolve the response or run the timeout counter
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      last_wr   <= 1'b0;
      cnt       <= '0;
      resp      <= 2'b00;
      rdata_q   <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wstrb <= '0;
    end else if (grant) begin
      last_wr  <= pick_wr;
      cnt      <= '0;
      reg_addr <= grant_off;
      if (pick_wr) begin
        reg_wdata <= wdata_q;
        reg_wstrb <= wstrb_q;
      end
      if (grant_dec) begin
        resp <= 2'b11;
        if (pick_rd) rdata_q <= '0;
      end
    end else if (state == WR_REQ || state == RD_REQ) begin
      if (reg_ack) begin
        resp <= reg_err ? 2'b10 : 2'b00;
        if (state == RD_REQ) rdata_q <= reg_rdata;
      end else if (timeout) begin
        resp <= 2'b10;
        if (state == RD_REQ) rdata_q <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_reg_axi_bridge.sv
// tb_reg_axi_bridge: scoreboard bench for the AXI-Lite to register-bus bridge
module tb_reg_axi_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 255;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] SPAN = 32'h0000_1000;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          width;
  } req_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          reg_wr_req, reg_rd_req, reg_ack, reg_err;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata, reg_rdata;
  logic [3:0]    reg_wstrb;

  req_t gq[$];
  rsp_t bq[$];
  rsp_t rq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int w_hs = 0;
  int r_hs = 0;
  int ack_delay = 0;
  bit ack_on = 1'b1;
  bit force_ack = 1'b0;
  bit ack_err = 1'b0;
  bit busy = 1'b0;
  logic [31:0] ack_data = '0;

  reg_axi_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_axi ();

  reg_axi_bridge #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .ADDR_BASE(BASE), .ADDR_SPAN(SPAN), .TIMEOUT_CYCLES(TO)
  ) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst), .s_axi(s_axi),
    .reg_wr_req(reg_wr_req), .reg_rd_req(reg_rd_req), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
    .reg_ack(reg_ack), .reg_err(reg_err), .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: condition occurred (got 1, required 0)", name);
  endtask

  // Register-side responder: ack on the (ack_delay+1)-th request cycle, or when forced
  initial begin
    int rc = 0;
    reg_ack = 1'b0;
    reg_err = 1'b0;
    reg_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      rc = (reg_wr_req || reg_rd_req) ? rc + 1 : 0;
      reg_ack = force_ack || (ack_on && rc == ack_delay + 1);
      reg_err = ack_err;
      reg_rdata = ack_data;
    end
  end

  // Register-side monitor: checks each request against the expected queue and its width
  initial begin
    req_t e;
    bit have_e = 1'b0;
    int w = 0;
    forever begin
      @(negedge clk);
      if (reg_wr_req || reg_rd_req) begin
        if (!busy) begin
          busy = 1'b1;
          w = 1;
          have_e = gq.size() > 0;
          if (!have_e) flag("unexpected_req");
          else begin
            e = gq.pop_front();
            check("req_type_wr", reg_wr_req, e.wr);
            check("req_excl", reg_wr_req && reg_rd_req, 0);
            check("req_addr", reg_addr, e.addr);
            if (e.wr) begin
              check("req_wdata", reg_wdata, e.data);
              check("req_wstrb", reg_wstrb, e.strb);
            end
          end
        end else w++;
      end else if (busy) begin
        busy = 1'b0;
        if (have_e) check("req_width", w, e.width);
      end
    end
  end

  // AXI response monitor: pops expected B/R on handshake, checks latency and R hold stability
  initial begin
    rsp_t eb, er;
    int bf = 0;
    int rf = 0;
    bit bp = 1'b0;
    bit rp = 1'b0;
    bit rw = 1'b0;
    logic [31:0] rd_s = '0;
    logic [1:0] rr_s = '0;
    forever begin
      @(negedge clk);
      if (s_axi.bvalid && !bp) bf = cyc;
      if (s_axi.rvalid && !rp) rf = cyc;
      bp = s_axi.bvalid;
      rp = s_axi.rvalid;
      if (rw && s_axi.rvalid) begin
        check("rdata_hold", s_axi.rdata, rd_s);
        check("rresp_hold", s_axi.rresp, rr_s);
      end
      rw = s_axi.rvalid && !s_axi.rready;
      rd_s = s_axi.rdata;
      rr_s = s_axi.rresp;
      if (s_axi.bvalid && s_axi.bready) begin
        if (bq.size() == 0) flag("unexpected_b");
        else begin
          eb = bq.pop_front();
          check("bresp", s_axi.bresp, eb.resp);
          if (eb.lat >= 0) check("b_latency", bf - w_hs, eb.lat);
        end
      end
      if (s_axi.rvalid && s_axi.rready) begin
        if (rq.size() == 0) flag("unexpected_r");
        else begin
          er = rq.pop_front();
          check("rresp", s_axi.rresp, er.resp);
          check("rdata", s_axi.rdata, er.data);
          if (er.lat >= 0) check("r_latency", rf - r_hs, er.lat);
        end
      end
    end
  end

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int gap);
    int n;
    if (gap > 0) begin
      s_axi.wdata = d;
      s_axi.wstrb = s;
      s_axi.wvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!s_axi.wready && n < 100);
      if (!s_axi.wready) flag("wready_wait");
      @(posedge clk);
      #1 s_axi.wvalid = 1'b0;
      repeat (gap - 1) begin @(posedge clk); #1; end
    end else begin
      s_axi.wdata = d;
      s_axi.wstrb = s;
      s_axi.wvalid = 1'b1;
    end
    s_axi.awaddr = a;
    s_axi.awvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(s_axi.awready && (gap > 0 || s_axi.wready)) && n < 100);
    if (n >= 100) flag("awready_wait");
    w_hs = cyc;
    @(posedge clk);
    #1 s_axi.awvalid = 1'b0;
    if (gap == 0) s_axi.wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a);
    int n = 0;
    s_axi.araddr = a;
    s_axi.arvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!s_axi.arready && n < 100);
    if (!s_axi.arready) flag("arready_wait");
    r_hs = cyc;
    @(posedge clk);
    #1 s_axi.arvalid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while ((bq.size() != 0 || rq.size() != 0 || gq.size() != 0 || busy) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) flag("wait_done");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rvalid(input int limit);
    int n = 0;
    do begin @(negedge clk); n++; end while (!s_axi.rvalid && n < limit);
    if (!s_axi.rvalid) flag("rvalid_wait");
  endtask

  task automatic pulse_ack();
    force_ack = 1'b1;
    @(posedge clk);
    #1 force_ack = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
    $fatal(1);
  end

  initial begin
    int n;
    s_axi.awaddr = '0; s_axi.awvalid = 1'b0;
    s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wvalid = 1'b0;
    s_axi.araddr = '0; s_axi.arvalid = 1'b0;
    s_axi.bready = 1'b1; s_axi.rready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_awready", s_axi.awready, 0);
    check("rst_wready", s_axi.wready, 0);
    check("rst_arready", s_axi.arready, 0);
    check("rst_bvalid", s_axi.bvalid, 0);
    check("rst_rvalid", s_axi.rvalid, 0);
    check("rst_bresp", s_axi.bresp, 0);
    check("rst_rresp", s_axi.rresp, 0);
    check("rst_rdata", s_axi.rdata, 0);
    check("rst_wr_req", reg_wr_req, 0);
    check("rst_rd_req", reg_rd_req, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_wdata", reg_wdata, 0);
    check("rst_reg_wstrb", reg_wstrb, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_awready", s_axi.awready, 1);
    check("post_rst_wready", s_axi.wready, 1);
    check("post_rst_arready", s_axi.arready, 1);
    @(posedge clk);
    #1;

    // Single write, ack in first REQ cycle
    gq.push_back('{1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 1});
    bq.push_back('{2'b00, 32'h0, 3});
    axi_write(BASE + 32'h10, 32'hA5A5_0001, 4'hF, 0);
    wait_done(50);

    // W three cycles ahead of AW, ack four cycles late
    ack_delay = 4;
    gq.push_back('{1'b1, 32'h24, 32'h0BAD_F00D, 4'hC, 5});
    bq.push_back('{2'b00, 32'h0, 7});
    axi_write(BASE + 32'h24, 32'h0BAD_F00D, 4'hC, 3);
    wait_done(50);

    // Read with rready held low for five cycles
    ack_delay = 0;
    ack_data = 32'h1234_5678;
    s_axi.rready = 1'b0;
    gq.push_back('{1'b0, 32'h20, 32'h0, 4'h0, 1});
    rq.push_back('{2'b00, 32'h1234_5678, 3});
    axi_read(BASE + 32'h20);
    wait_rvalid(50);
    repeat (5) @(posedge clk);
    #1 s_axi.rready = 1'b1;
    wait_done(50);

    // Tie arbitration from reset: W, R, W, R
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    ack_data = 32'h0000_00C3;
    gq.push_back('{1'b1, 32'h30, 32'h1111_2222, 4'h3, 1});
    gq.push_back('{1'b0, 32'h34, 32'h0, 4'h0, 1});
    bq.push_back('{2'b00, 32'h0, 3});
    rq.push_back('{2'b00, 32'h0000_00C3, 6});
    fork
      axi_write(BASE + 32'h30, 32'h1111_2222, 4'h3, 0);
      axi_read(BASE + 32'h34);
    join
    wait_done(50);
    gq.push_back('{1'b1, 32'h38, 32'h3333_4444, 4'hF, 1});
    gq.push_back('{1'b0, 32'h3C, 32'h0, 4'h0, 1});
    bq.push_back('{2'b00, 32'h0, 3});
    rq.push_back('{2'b00, 32'h0000_00C3, 6});
    fork
      axi_write(BASE + 32'h38, 32'h3333_4444, 4'hF, 0);
      axi_read(BASE + 32'h3C);
    join
    wait_done(50);

    // Outside the window: at BASE+SPAN and below BASE
    bq.push_back('{2'b11, 32'h0, 2});
    axi_write(BASE + SPAN, 32'hFFFF_FFFF, 4'hF, 0);
    wait_done(50);
    rq.push_back('{2'b11, 32'h0, 2});
    axi_read(BASE + SPAN);
    wait_done(50);
    rq.push_back('{2'b11, 32'h0, 2});
    axi_read(BASE - 32'h4);
    wait_done(50);

    // Register error with ack
    ack_err = 1'b1;
    ack_data = 32'h0000_5555;
    gq.push_back('{1'b1, 32'h40, 32'h0000_0040, 4'h1, 1});
    bq.push_back('{2'b10, 32'h0, 3});
    axi_write(BASE + 32'h40, 32'h0000_0040, 4'h1, 0);
    wait_done(50);
    gq.push_back('{1'b0, 32'h44, 32'h0, 4'h0, 1});
    rq.push_back('{2'b10, 32'h0000_5555, 3});
    axi_read(BASE + 32'h44);
    wait_done(50);
    ack_err = 1'b0;

    // Timeout on a read, then late acks in RESP and in IDLE are ignored
    ack_on = 1'b0;
    ack_data = 32'hDEAD_BEEF;
    s_axi.rready = 1'b0;
    gq.push_back('{1'b0, 32'h50, 32'h0, 4'h0, TO});
    rq.push_back('{2'b10, 32'h0, TO + 2});
    axi_read(BASE + 32'h50);
    wait_rvalid(400);
    @(posedge clk);
    #1 pulse_ack();
    repeat (2) @(posedge clk);
    #1 s_axi.rready = 1'b1;
    wait_done(50);
    pulse_ack();
    repeat (4) @(posedge clk);
    #1;

    // Ack on the last permitted REQ cycle wins over the timeout
    ack_on = 1'b1;
    ack_delay = TO - 1;
    gq.push_back('{1'b1, 32'h60, 32'h7777_8888, 4'hF, TO});
    bq.push_back('{2'b00, 32'h0, TO + 2});
    axi_write(BASE + 32'h60, 32'h7777_8888, 4'hF, 0);
    wait_done(400);

    // Reset in the middle of a request
    ack_on = 1'b0;
    ack_delay = 0;
    gq.push_back('{1'b1, 32'h70, 32'h9999_0000, 4'hF, 4});
    axi_write(BASE + 32'h70, 32'h9999_0000, 4'hF, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!busy && n < 20);
    if (!busy) flag("req_start_wait");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_wr_req", reg_wr_req, 0);
    check("midrst_bvalid", s_axi.bvalid, 0);
    check("midrst_awready", s_axi.awready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    ack_on = 1'b1;
    @(negedge clk);
    check("midrst_awready_after", s_axi.awready, 1);
    check("midrst_wready_after", s_axi.wready, 1);
    check("midrst_arready_after", s_axi.arready, 1);
    repeat (6) @(posedge clk);
    #1;

    // After reset a tie goes to write again
    ack_data = 32'h0F0F_0F0F;
    gq.push_back('{1'b1, 32'h80, 32'hABCD_0123, 4'h5, 1});
    gq.push_back('{1'b0, 32'h84, 32'h0, 4'h0, 1});
    bq.push_back('{2'b00, 32'h0, 3});
    rq.push_back('{2'b00, 32'h0F0F_0F0F, 6});
    fork
      axi_write(BASE + 32'h80, 32'hABCD_0123, 4'h5, 0);
      axi_read(BASE + 32'h84);
    join
    wait_done(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
